dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001: Parameter DEPTH, 256, number of 32-bit words stored; power of two.
REQ-002: Parameter LATENCY, 2, wait cycles between request accept and response; range 0..15.
REQ-003: clk  input  1  single clock; all state updates on rising edge.
REQ-004: reset  input  1  asynchronous, active-low reset.
REQ-005: req_valid  input  1  initiator presents a request.
REQ-006: req_ready  output  1  responder can accept a request.
REQ-007: req_we  input  1  1 = store, 0 = load.
REQ-008: req_addr  input  32  byte address.
REQ-009: req_wdata  input  32  store data; low bytes used for sb/sh.
REQ-010: req_funct3  input  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-011: resp_valid  output  1  response available.
REQ-012: resp_ready  input  1  initiator consumes the response.
REQ-013: resp_rdata  output  32  load data, extended per funct3; 0 for stores and errors.
REQ-014: resp_err  output  1  request was misaligned or had an illegal funct3.

Function
REQ-015: FSM states IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-016: IDLE: on req_valid & req_ready, capture we/addr/wdata/funct3, load counter = LATENCY, go to WAIT; if LATENCY = 0, go directly to RESP.
REQ-017: WAIT: counter decrements once per cycle; transition to RESP on the edge where counter = 1; req_valid ignored.
REQ-018: resp_valid SHALL rise exactly LATENCY+1 cycles after the accepting edge.
REQ-019: RESP: resp_valid = 1; resp_rdata and resp_err held stable until the edge with resp_ready = 1, then go to IDLE; no back-to-back accept in that same cycle.
REQ-020: Word index = addr[log2(DEPTH)+1:2]; upper address bits ignored, so addresses alias modulo 4*DEPTH bytes.
REQ-021: Little-endian byte lanes: byte n of a word = bits [8n+7:8n], n = addr[1:0].
REQ-022: Store commit on the edge entering RESP: sb writes byte lane addr[1:0]; sh writes lanes addr[1]*2 and +1; sw writes all four; other lanes unchanged.
REQ-023: Load data is sampled from memory on the edge entering RESP. lb/lh sign-extend; lbu/lhu zero-extend; lw returns the word.
REQ-024: Error when h/hu/sh has addr[0] = 1, w/sw has addr[1:0] != 0, store funct3 is not 000/001/010, or load funct3 is 011/110/111.
REQ-025: On error: resp_err = 1, resp_rdata = 0, memory unmodified; response timing is the same as for a legal access.
REQ-026: Memory has no read/write hazard: a load issued after a store's response completes SHALL observe the stored data.

Reset
REQ-027: While reset = 0: state IDLE, counter 0, resp_valid 0, resp_rdata 0, resp_err 0, req_ready 1 (after release).
REQ-028: Reset mid-transaction aborts the transaction: a store in WAIT is discarded with no commit and no response issued.
REQ-029: Memory array is not reset; contents persist across reset.

Verification
REQ-030: LATENCY=2: sw 0x00000019 @0x64, then lw @0x64 -> resp_valid 3 cycles after each accept, rdata 0x00000019, err 0.
REQ-031: sw 0x11223344 @0x60; sb 0x80 @0x61; lw @0x60 -> 0x11228044; lb @0x61 -> 0xFFFFFF80; lbu @0x61 -> 0x00000080; lhu @0x62 -> 0x00001122.
REQ-032: sh @0x63 and lw @0x62 -> resp_err 1, rdata 0; subsequent lw @0x60 -> 0x11228044 (unchanged).
REQ-033: Hold resp_ready = 0 for 5 cycles in RESP while driving req_valid -> resp_valid, rdata, and err are stable; req_ready 0; no new request accepted; IDLE one edge after resp_ready = 1.
REQ-034: sw 0 @0x10; sw 0xDEADBEEF @0x10 with reset pulsed low during WAIT -> all outputs go to reset values immediately, no response is issued; lw @0x10 -> 0x00000000.
REQ-035: DEPTH=256: sw 0xCAFEF00D @0x400; lw @0x000 -> 0xCAFEF00D (aliasing); also LATENCY=0: resp_valid 1 cycle after accept.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Request/response bus between a load/store initiator and the data memory responder.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_funct3, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_funct3, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data memory responder with fixed wait latency, byte/half/word
// little-endian access, sign/zero extension and misalignment/illegal-size errors.
module dmem_responder #(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input logic             clk,
    input logic             reset,
    dmem_responder_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [31:0] addr_q, wdata_q;
    logic [2:0]  funct3_q;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [31:0] mem [DEPTH];

    logic        accept, enter_resp;
    logic        cur_we;
    logic [31:0] cur_addr, cur_wdata;
    logic [2:0]  cur_f3;
    logic [AW-1:0] idx;
    logic [1:0]  lane;
    logic [31:0] word, wlanes;
    logic [3:0]  wmask;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic        bad;
    logic        unused_addr;

    // Ready is held low while reset is asserted so nothing is accepted or committed.
    assign bus.req_ready  = reset && (state_q == StIdle);
    assign accept         = bus.req_valid && bus.req_ready;
    assign bus.resp_valid = (state_q == StResp);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

    // Next-state and wait counter; enter_resp marks the commit/sample edge.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (LATENCY == 0) begin
                        state_d    = StResp;
                        cnt_d      = 4'd0;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = StWait;
                        cnt_d   = 4'(LATENCY);
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d    = StResp;
                    enter_resp = 1'b1;
                end
            end
            StResp: begin
                if (bus.resp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // With zero latency the commit happens on the accepting edge, before capture.
    always_comb begin
        cur_we    = we_q;
        cur_addr  = addr_q;
        cur_wdata = wdata_q;
        cur_f3    = funct3_q;
        if (state_q == StIdle) begin
            cur_we    = bus.req_we;
            cur_addr  = bus.req_addr;
            cur_wdata = bus.req_wdata;
            cur_f3    = bus.req_funct3;
        end
    end

    assign idx         = cur_addr[AW+1:2];
    assign lane        = cur_addr[1:0];
    assign word        = mem[idx];
    assign rbyte       = word[{lane, 3'b000} +: 8];
    assign rhalf       = lane[1] ? word[31:16] : word[15:0];
    assign unused_addr = ^cur_addr[31:AW+2];

    // Legality check, store lane mask and load extension for the current access.
    always_comb begin
        bad     = 1'b0;
        wmask   = 4'b1111;
        wlanes  = cur_wdata;
        rdata_d = 32'd0;
        case (cur_f3)
            3'b000:         bad = 1'b0;
            3'b001:         bad = cur_addr[0];
            3'b010:         bad = |cur_addr[1:0];
            3'b100, 3'b101: bad = cur_we | (cur_f3[0] & cur_addr[0]);
            default:        bad = 1'b1;
        endcase
        case (cur_f3[1:0])
            2'b00: begin
                wmask  = 4'b0001 << lane;
                wlanes = {4{cur_wdata[7:0]}};
            end
            2'b01: begin
                wmask  = lane[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{cur_wdata[15:0]}};
            end
            default: begin
                wmask  = 4'b1111;
                wlanes = cur_wdata;
            end
        endcase
        if (!bad && !cur_we) begin
            case (cur_f3)
                3'b000:  rdata_d = {{24{rbyte[7]}}, rbyte};
                3'b100:  rdata_d = {24'd0, rbyte};
                3'b001:  rdata_d = {{16{rhalf[15]}}, rhalf};
                3'b101:  rdata_d = {16'd0, rhalf};
                3'b010:  rdata_d = word;
                default: rdata_d = 32'd0;
            endcase
        end
        err_d = bad;
    end

    // Control state, captured request and registered response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            cnt_q    <= 4'd0;
            we_q     <= 1'b0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            funct3_q <= 3'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q     <= bus.req_we;
                addr_q   <= bus.req_addr;
                wdata_q  <= bus.req_wdata;
                funct3_q <= bus.req_funct3;
            end
            if (enter_resp) begin
                rdata_q <= rdata_d;
                err_q   <= err_d;
            end
        end
    end

    // Store commit; the array is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (enter_resp && cur_we && !bad) begin
            for (int n = 0; n < 4; n++) begin
                if (wmask[n]) mem[idx][8*n +: 8] <= wlanes[8*n +: 8];
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2/DEPTH=256 instance and a
// LATENCY=0/DEPTH=16 instance, checked against hand-computed values.
module tb_dmem_responder;
    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    dmem_responder_if bus ();
    dmem_responder_if bus0 ();

    dmem_responder #(.DEPTH(256), .LATENCY(2)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    dmem_responder #(.DEPTH(16), .LATENCY(0)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    // Compare one observed value against its expected value.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // One complete transaction on the selected instance (sel=1 -> LATENCY=0 instance).
    task automatic xact(input bit sel, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input string tag);
        int   lat;
        logic rv, rr;
        logic [31:0] rd;
        logic er;
        @(negedge clk);
        if (sel) begin
            bus0.req_valid = 1'b1; bus0.req_we = we; bus0.req_funct3 = f3;
            bus0.req_addr = addr; bus0.req_wdata = wdata; bus0.resp_ready = 1'b1;
            rr = bus0.req_ready;
        end else begin
            bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
            bus.req_addr = addr; bus.req_wdata = wdata; bus.resp_ready = 1'b1;
            rr = bus.req_ready;
        end
        check({tag, ".ready"}, 32'(rr), 32'd1);
        @(posedge clk); #1;
        if (sel) bus0.req_valid = 1'b0; else bus.req_valid = 1'b0;
        lat = 1;
        rv  = sel ? bus0.resp_valid : bus.resp_valid;
        while (!rv && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            rv = sel ? bus0.resp_valid : bus.resp_valid;
        end
        rd = sel ? bus0.resp_rdata : bus.resp_rdata;
        er = sel ? bus0.resp_err : bus.resp_err;
        check({tag, ".lat"}, 32'(lat), sel ? 32'd1 : 32'd3);
        check({tag, ".rdata"}, rd, exp_rdata);
        check({tag, ".err"}, 32'(er), 32'(exp_err));
        @(posedge clk); #1;
        rv = sel ? bus0.resp_valid : bus.resp_valid;
        check({tag, ".done"}, 32'(rv), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        logic seen;
        bus.req_valid = 1'b0;  bus.req_we = 1'b0;  bus.req_addr = '0;
        bus.req_wdata = '0;    bus.req_funct3 = '0; bus.resp_ready = 1'b0;
        bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = '0;
        bus0.req_wdata = '0;   bus0.req_funct3 = '0; bus0.resp_ready = 1'b0;

        #12;
        check("rst.valid", 32'(bus.resp_valid), 32'd0);
        check("rst.rdata", bus.resp_rdata, 32'd0);
        check("rst.err", 32'(bus.resp_err), 32'd0);
        check("rst0.valid", 32'(bus0.resp_valid), 32'd0);
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        check("rst.ready", 32'(bus.req_ready), 32'd1);

        xact(0, 1'b1, F_W, 32'h64, 32'h19, 32'h0, 1'b0, "sw64");
        xact(0, 1'b0, F_W, 32'h64, 32'h0, 32'h19, 1'b0, "lw64");

        xact(0, 1'b1, F_W, 32'h60, 32'h11223344, 32'h0, 1'b0, "sw60");
        xact(0, 1'b1, F_B, 32'h61, 32'h80, 32'h0, 1'b0, "sb61");
        xact(0, 1'b0, F_W, 32'h60, 32'h0, 32'h11228044, 1'b0, "lw60");
        xact(0, 1'b0, F_B, 32'h61, 32'h0, 32'hFFFFFF80, 1'b0, "lb61");
        xact(0, 1'b0, F_BU, 32'h61, 32'h0, 32'h00000080, 1'b0, "lbu61");
        xact(0, 1'b0, F_HU, 32'h62, 32'h0, 32'h00001122, 1'b0, "lhu62");
        xact(0, 1'b0, F_H, 32'h60, 32'h0, 32'hFFFF8044, 1'b0, "lh60");

        xact(0, 1'b1, F_H, 32'h63, 32'hFFFF, 32'h0, 1'b1, "sh63");
        xact(0, 1'b0, F_W, 32'h62, 32'h0, 32'h0, 1'b1, "lw62");
        xact(0, 1'b0, 3'b011, 32'h60, 32'h0, 32'h0, 1'b1, "ld011");
        xact(0, 1'b1, F_BU, 32'h60, 32'hFF, 32'h0, 1'b1, "st100");
        xact(0, 1'b0, F_W, 32'h60, 32'h0, 32'h11228044, 1'b0, "lw60b");

        // Response back-pressure with a competing request held on the bus.
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = F_W;
        bus.req_addr = 32'h60; bus.resp_ready = 1'b0;
        @(posedge clk); #1;
        bus.req_we = 1'b1; bus.req_wdata = 32'hFFFFFFFF;
        lat = 1;
        while (!bus.resp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("hold.lat", 32'(lat), 32'd3);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("hold.valid", 32'(bus.resp_valid), 32'd1);
            check("hold.rdata", bus.resp_rdata, 32'h11228044);
            check("hold.err", 32'(bus.resp_err), 32'd0);
            check("hold.ready", 32'(bus.req_ready), 32'd0);
        end
        @(negedge clk);
        bus.resp_ready = 1'b1; bus.req_valid = 1'b0;
        @(posedge clk); #1;
        check("hold.release", 32'(bus.resp_valid), 32'd0);
        check("hold.idle", 32'(bus.req_ready), 32'd1);
        xact(0, 1'b0, F_W, 32'h60, 32'h0, 32'h11228044, 1'b0, "lw60c");

        xact(0, 1'b1, F_H, 32'h62, 32'hBEEF, 32'h0, 1'b0, "sh62");
        xact(0, 1'b0, F_W, 32'h60, 32'h0, 32'hBEEF8044, 1'b0, "lw60d");

        // Reset while a store waits: no commit, no response.
        xact(0, 1'b1, F_W, 32'h10, 32'h0, 32'h0, 1'b0, "sw10");
        xact(0, 1'b0, F_W, 32'h60, 32'h0, 32'hBEEF8044, 1'b0, "lw60e");
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = F_W;
        bus.req_addr = 32'h10; bus.req_wdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        #2 reset = 1'b0;
        #1;
        check("mrst.valid", 32'(bus.resp_valid), 32'd0);
        check("mrst.rdata", bus.resp_rdata, 32'd0);
        check("mrst.err", 32'(bus.resp_err), 32'd0);
        @(negedge clk);
        @(negedge clk); reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            seen = seen | bus.resp_valid;
        end
        check("mrst.noresp", 32'(seen), 32'd0);
        check("mrst.ready", 32'(bus.req_ready), 32'd1);
        xact(0, 1'b0, F_W, 32'h10, 32'h0, 32'h0, 1'b0, "lw10");

        xact(0, 1'b1, F_W, 32'h400, 32'hCAFEF00D, 32'h0, 1'b0, "sw400");
        xact(0, 1'b0, F_W, 32'h000, 32'h0, 32'hCAFEF00D, 1'b0, "lw000");

        xact(1, 1'b1, F_W, 32'h04, 32'h12345678, 32'h0, 1'b0, "z.sw04");
        xact(1, 1'b0, F_W, 32'h44, 32'h0, 32'h12345678, 1'b0, "z.lw44");
        xact(1, 1'b0, F_B, 32'h07, 32'h0, 32'h00000012, 1'b0, "z.lb07");
        xact(1, 1'b0, F_W, 32'h06, 32'h0, 32'h0, 1'b1, "z.lw06");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
